// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - registered immediate-extension stage with prefix pairing
// Sign/zero/upper extension, plus a held prefix that supplies the high bits of the next immediate.
module imm_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_pfx,
    output logic              pfx_pending
);
    localparam int PFX_W = DATA_W - IMM_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    state_t              r_state;
    logic [PFX_W-1:0]    r_prefix;
    logic [DATA_W-1:0]   r_out_imm;
    logic                r_out_valid;
    logic                r_out_pfx;

    logic                w_accept;
    logic                w_is_pfx;
    logic [DATA_W-1:0]   w_ext;

    assign in_ready    = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_is_pfx    = (in_mode == 2'b11);
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_pfx     = r_out_pfx;
    assign pfx_pending = (r_state == ST_HELD);

    // A held prefix overrides the mode of its partner instruction.
    always_comb begin
        w_ext = '0;
        if (r_state == ST_HELD) begin
            w_ext = {r_prefix, in_imm};
        end else begin
            case (in_mode)
                2'b00:   w_ext = {{PFX_W{in_imm[IMM_W-1]}}, in_imm};
                2'b01:   w_ext = {{PFX_W{1'b0}}, in_imm};
                2'b10:   w_ext = {in_imm, {PFX_W{1'b0}}};
                default: w_ext = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prefix    <= '0;
            r_out_imm   <= '0;
            r_out_valid <= 1'b0;
            r_out_pfx   <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_pfx   <= 1'b0;
        end else if (w_accept && w_is_pfx) begin
            r_prefix    <= in_imm[PFX_W-1:0];
            r_state     <= ST_HELD;
            r_out_valid <= r_out_valid && !out_ready;
        end else if (w_accept) begin
            r_out_imm   <= w_ext;
            r_out_pfx   <= (r_state == ST_HELD);
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
